// File: rtl/instr_fetch.sv
// Instruction fetch: program memory, PC sequencing, branch redirect and stall.
// One-cycle registered fetch; the redirect cycle is a bubble.
module instr_fetch #(
  parameter int unsigned IW = 16,
  parameter int unsigned AW = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          BE,
  input  logic [AW-1:0] BranchADR,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  output logic [IW-1:0] IOut,
  output logic [AW-1:0] pc_out,
  output logic          ivalid
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW-1:0] PC_ONE = 1;

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] pc;

  // Program load is independent of reset so the image survives it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read of mem[pc] sees the pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      IOut   <= '0;
      pc_out <= '0;
      ivalid <= 1'b0;
    end else if (BE) begin
      pc     <= BranchADR;
      ivalid <= 1'b0;
    end else if (!stall) begin
      IOut   <= mem[pc];
      pc_out <= pc;
      ivalid <= 1'b1;
      pc     <= pc + PC_ONE;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
// Two instances share stimulus: default RESET_PC and RESET_PC=2.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        BE;
  logic [3:0]  BranchADR;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;

  logic [15:0] iout0, iout2;
  logic [3:0]  pco0, pco2;
  logic        iv0, iv2;

  int nchk;
  int nfail;

  instr_fetch #(.IW(16), .AW(4)) u0 (
    .clk(clk), .rst(rst), .stall(stall),
    .BE(BE), .BranchADR(BranchADR),
    .we(we), .waddr(waddr), .wdata(wdata),
    .IOut(iout0), .pc_out(pco0), .ivalid(iv0)
  );

  instr_fetch #(.IW(16), .AW(4), .RESET_PC(4'd2)) u2 (
    .clk(clk), .rst(rst), .stall(stall),
    .BE(BE), .BranchADR(BranchADR),
    .we(we), .waddr(waddr), .wdata(wdata),
    .IOut(iout2), .pc_out(pco2), .ivalid(iv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_program;
    rst = 1'b1;
    we  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      waddr = 4'(i);
      wdata = 16'h1000 + 16'(i);
      step();
    end
    we = 1'b0;
  endtask

  task automatic test_reset;
    logic [20:0] exp;
    do_reset();
    exp = 21'h0;
    nchk++;
    if ({iv0, pco0, iout0} !== exp) begin
      nfail++;
      $display("FAIL reset: got %h want %h", {iv0, pco0, iout0}, exp);
    end
  endtask

  task automatic test_free_run;
    logic [20:0] exp;
    for (int i = 0; i < 17; i++) begin
      step();
      exp = {1'b1, 4'(i % 16), 16'h1000 + 16'(i % 16)};
      nchk++;
      if ({iv0, pco0, iout0} !== exp) begin
        nfail++;
        $display("FAIL run[%0d]: got %h want %h", i, {iv0, pco0, iout0}, exp);
      end
    end
  endtask

  task automatic test_redirect;
    logic [20:0] exp [3];
    exp[0] = {1'b0, 4'd2, 16'h1002};
    exp[1] = {1'b1, 4'd12, 16'h100C};
    exp[2] = {1'b1, 4'd13, 16'h100D};
    do_reset();
    repeat (3) step();
    BE = 1'b1;
    BranchADR = 4'd12;
    for (int i = 0; i < 3; i++) begin
      step();
      BE = 1'b0;
      nchk++;
      if ({iv0, pco0, iout0} !== exp[i]) begin
        nfail++;
        $display("FAIL redirect[%0d]: got %h want %h", i, {iv0, pco0, iout0}, exp[i]);
      end
    end
  endtask

  task automatic test_stall;
    logic [20:0] exp;
    do_reset();
    repeat (6) step();
    stall = 1'b1;
    exp = {1'b1, 4'd5, 16'h1005};
    for (int i = 0; i < 3; i++) begin
      step();
      nchk++;
      if ({iv0, pco0, iout0} !== exp) begin
        nfail++;
        $display("FAIL stall[%0d]: got %h want %h", i, {iv0, pco0, iout0}, exp);
      end
    end
    stall = 1'b0;
    step();
    exp = {1'b1, 4'd6, 16'h1006};
    nchk++;
    if ({iv0, pco0, iout0} !== exp) begin
      nfail++;
      $display("FAIL stall_rel: got %h want %h", {iv0, pco0, iout0}, exp);
    end
  endtask

  task automatic test_priority;
    logic [20:0] exp [3];
    exp[0] = {1'b0, 4'd6, 16'h1006};
    exp[1] = {1'b0, 4'd6, 16'h1006};
    exp[2] = {1'b1, 4'd9, 16'h1009};
    stall = 1'b1;
    BE = 1'b1;
    BranchADR = 4'd9;
    step();
    BE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) step();
      nchk++;
      if ({iv0, pco0, iout0} !== exp[i]) begin
        nfail++;
        $display("FAIL prio[%0d]: got %h want %h", i, {iv0, pco0, iout0}, exp[i]);
      end
      if (i == 0) step();
      if (i == 1) stall = 1'b0;
    end
  endtask

  task automatic test_collision;
    logic [20:0] exp [3];
    exp[0] = {1'b1, 4'd7, 16'h1007};
    exp[1] = {1'b0, 4'd7, 16'h1007};
    exp[2] = {1'b1, 4'd7, 16'hBEEF};
    do_reset();
    repeat (7) step();
    we = 1'b1;
    waddr = 4'd7;
    wdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      we = 1'b0;
      BE = (i == 0);
      BranchADR = 4'd7;
      nchk++;
      if ({iv0, pco0, iout0} !== exp[i]) begin
        nfail++;
        $display("FAIL collide[%0d]: got %h want %h", i, {iv0, pco0, iout0}, exp[i]);
      end
    end
    BE = 1'b0;
  endtask

  task automatic test_self_branch;
    logic [20:0] exp;
    BE = 1'b1;
    BranchADR = 4'd8;
    exp = {1'b0, 4'd7, 16'hBEEF};
    for (int i = 0; i < 3; i++) begin
      step();
      nchk++;
      if ({iv0, pco0, iout0} !== exp) begin
        nfail++;
        $display("FAIL selfbr[%0d]: got %h want %h", i, {iv0, pco0, iout0}, exp);
      end
    end
    BE = 1'b0;
    step();
    exp = {1'b1, 4'd8, 16'h1008};
    nchk++;
    if ({iv0, pco0, iout0} !== exp) begin
      nfail++;
      $display("FAIL selfbr_rel: got %h want %h", {iv0, pco0, iout0}, exp);
    end
  endtask

  task automatic test_mid_reset;
    logic [20:0] exp [5];
    exp[0] = {1'b1, 4'd10, 16'h100A};
    exp[1] = 21'h0;
    exp[2] = {1'b1, 4'd2, 16'h1002};
    exp[3] = {1'b1, 4'd3, 16'h1003};
    exp[4] = {1'b1, 4'd7, 16'hBEEF};
    do_reset();
    repeat (9) step();
    for (int i = 0; i < 5; i++) begin
      nchk++;
      if ({iv2, pco2, iout2} !== exp[i]) begin
        nfail++;
        $display("FAIL midrst[%0d]: got %h want %h", i, {iv2, pco2, iout2}, exp[i]);
      end
      rst = (i == 0);
      if (i == 3) repeat (4) step();
      else step();
    end
    rst = 1'b0;
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    rst = 1'b1;
    stall = 1'b0;
    BE = 1'b0;
    BranchADR = '0;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    @(negedge clk);
    load_program();
    test_reset();
    test_free_run();
    test_redirect();
    test_stall();
    test_priority();
    test_collision();
    test_self_branch();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter IW, default 16, instruction word width in bits.
REQ-002 SHALL provide parameter AW, default 4, PC/address width; memory depth is 2**AW words.
REQ-003 SHALL provide parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 stall  input  1  hold the PC and all fetch outputs.
REQ-008 BE  input  1  branch enable; redirects the PC to BranchADR.
REQ-009 BranchADR  input  AW  branch target address.
REQ-010 we  input  1  program-load write enable.
REQ-011 waddr  input  AW  program-load write address.
REQ-012 wdata  input  IW  program-load write data.
REQ-013 IOut  output  IW  fetched instruction (registered).
REQ-014 pc_out  output  AW  address that IOut was fetched from (registered).
REQ-015 ivalid  output  1  IOut/pc_out hold a valid fetched instruction.

Function
REQ-016 SHALL hold 2**AW words of IW bits in internal memory; memory SHALL NOT be cleared by rst.
REQ-017 On a rising edge with we=1, mem[waddr] SHALL take wdata, regardless of rst, stall or BE.
REQ-018 Fetch (rst=0, BE=0, stall=0): IOut<=mem[PC], pc_out<=PC, ivalid<=1, PC<=PC+1; latency one cycle from PC to IOut.
REQ-019 PC increment SHALL wrap modulo 2**AW (PC=2**AW-1 -> 0); no overflow flag.
REQ-020 Redirect (rst=0, BE=1): PC<=BranchADR, ivalid<=0, IOut and pc_out hold; the redirect cycle is a one-cycle bubble.
REQ-021 First fetch after redirect SHALL return mem[BranchADR] with pc_out=BranchADR, one cycle after the redirect edge.
REQ-022 Stall (rst=0, BE=0, stall=1): PC, IOut, pc_out and ivalid SHALL all hold.
REQ-023 BE=1 and stall=1 on the same edge: the redirect SHALL take priority and REQ-020 applies.
REQ-024 Read/write collision (we=1, waddr==PC on a fetch edge): IOut SHALL receive the old contents; the new data is visible on the next fetch of that address.
REQ-025 BE=1 with BranchADR equal to the current PC SHALL be legal and SHALL produce a bubble every cycle while BE is held.
REQ-026 No internal state other than PC, IOut, pc_out, ivalid and the memory array.

Reset
REQ-027 When rst=1 at a rising edge: PC<=RESET_PC, IOut<=0, pc_out<=0, ivalid<=0; stall and BE are ignored.
REQ-028 Reset mid-stream SHALL discard any in-progress fetch; the first fetch edge after rst falls SHALL return mem[RESET_PC].
REQ-029 Outputs SHALL be undefined only before the first reset edge; the bench SHALL apply rst for at least 1 cycle.

Verification
REQ-030 Load words 0..15 with 16'h1000+i, then reset and run 17 free cycles -> IOut = 16'h1000..16'h100F with pc_out 0..15, then 16'h1000 at pc_out 0 (wrap); ivalid=1 throughout.
REQ-031 Redirect test: at PC=3 assert BE=1 with BranchADR=12 for 1 cycle -> one cycle ivalid=0 with IOut held at the previous value, then IOut=mem[12] with pc_out=12, then mem[13].
REQ-032 Stall test: assert stall for 3 cycles at pc_out=5 -> IOut, pc_out=5 and ivalid held for 3 cycles; next edge -> pc_out=6.
REQ-033 Priority test: assert stall=1 and BE=1 with BranchADR=9 -> bubble, then mem[9] once stall is released.
REQ-034 Collision test: on the edge that fetches PC=7, write 16'hBEEF to address 7 -> IOut = old mem[7]; after a redirect to 7, IOut=16'hBEEF.
REQ-035 Reset mid-run: assert rst at pc_out=10 with RESET_PC=2 -> ivalid=0, IOut=0, pc_out=0; after release -> mem[2] at pc_out 2; memory contents intact.
